sevenseg_scan_ctrl: RTL

Memory-mapped controller that time-multiplexes a NUM_DIGITS-digit common-anode seven-segment display from picosoc's iomem bus. Firmware writes one hex nibble per digit plus enable and decimal-point masks. The block scans the digits round-robin, inserts an anti-ghosting blank gap at each digit change, and drives registered, active-low anode, segment and DP pins. It sits beside the GPIO peripheral in the FPGA top level.

---
 rtl/sevenseg_pkg.sv | 36 +++
 rtl/sevenseg_scan_ctrl_if.sv | 19 +
 rtl/seg_hex_decode.sv | 9 +
 rtl/sevenseg_scan_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared register offsets, blank pattern and hex decode for the scan controller
package sevenseg_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit6 = a ... bit0 = g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] s;
    s = SEG_BLANK;
    case (nibble)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// rtl/sevenseg_scan_ctrl_if.sv - picosoc iomem bus bundle for the seven-segment controller
interface sevenseg_scan_ctrl_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble to active-low seven-segment decoder
module seg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - iomem-mapped round-robin scanner for a common-anode seven-segment display
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0300_0000,
  parameter int          NUM_DIGITS   = 8,
  parameter int          SCAN_DIV     = 100_000,
  parameter int          BLANK_CYCLES = 1_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  sevenseg_scan_ctrl_if.slave   bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int             CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  BLANK_C  = CW'(BLANK_CYCLES);
  localparam logic [2:0]     IDX_MAX  = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]     DIG_MASK = 8'((1 << NUM_DIGITS) - 1);

  logic [31:0]   data_q, data_nxt;
  logic [7:0]    en_q, dpm_q, en_nxt, dpm_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx, idx_nxt;
  logic [3:0]    nib_lat;
  logic          dp_lat;
  logic          ready_q;
  logic [31:0]   rdata_q, rd_mux;
  logic          sel, acc, wr, blank, wrap;
  logic [1:0]    off;
  logic [6:0]    dec_seg, seg_nxt;
  logic [7:0]    an8;
  logic          dp_nxt;

  assign sel     = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
  // Gating on ready_q guarantees a low cycle between acknowledges
  assign acc     = sel && !ready_q;
  assign wr      = acc && (bus.iomem_wstrb != 4'b0000);
  assign off     = bus.iomem_addr[3:2];
  assign blank   = cnt < BLANK_C;
  assign wrap    = cnt == CNT_MAX;
  assign idx_nxt = (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;

  always_comb begin
    data_nxt = data_q;
    for (int b = 0; b < 4; b++) begin
      if (bus.iomem_wstrb[b]) data_nxt[8*b +: 8] = bus.iomem_wdata[8*b +: 8];
    end
    en_nxt  = bus.iomem_wstrb[0] ? bus.iomem_wdata[7:0]  : en_q;
    dpm_nxt = bus.iomem_wstrb[1] ? bus.iomem_wdata[15:8] : dpm_q;
  end

  always_comb begin
    rd_mux = 32'h0;
    case (off)
      REG_DATA:   rd_mux = data_q;
      REG_CTRL:   rd_mux = {16'h0, dpm_q, en_q};
      REG_STATUS: rd_mux = {28'h0, blank, idx};
      default:    rd_mux = 32'h0;
    endcase
  end

  seg_hex_decode u_dec (
    .nibble (nib_lat),
    .seg    (dec_seg)
  );

  always_comb begin
    an8     = 8'hFF;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (!blank && en_q[idx]) begin
      an8[idx] = 1'b0;
      seg_nxt  = dec_seg;
      dp_nxt   = ~dp_lat;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q  <= 32'h0;
      en_q    <= 8'h0;
      dpm_q   <= 8'h0;
      cnt     <= '0;
      idx     <= 3'd0;
      nib_lat <= 4'h0;
      dp_lat  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      an      <= '1;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      ready_q <= acc;
      rdata_q <= acc ? rd_mux : 32'h0;
      if (wr && off == REG_DATA) data_q <= data_nxt;
      if (wr && off == REG_CTRL) begin
        en_q  <= en_nxt & DIG_MASK;
        dpm_q <= dpm_nxt & DIG_MASK;
      end
      // The incoming digit's nibble is frozen for the whole slot to avoid tearing
      if (wrap) begin
        cnt     <= '0;
        idx     <= idx_nxt;
        nib_lat <= data_q[{idx_nxt, 2'b00} +: 4];
        dp_lat  <= dpm_q[idx_nxt];
      end else begin
        cnt <= cnt + 1'b1;
      end
      an  <= an8[NUM_DIGITS-1:0];
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.iomem_addr[7:4], bus.iomem_addr[1:0], an8};

endmodule
